// File: rtl/pwls_output_pkg.sv
// Shared constants and helpers for the PWL synth PWM output stage.
package pwls_output_pkg;

    localparam int unsigned MAX_W     = 32;
    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [MAX_W-1:0] midscale(input int unsigned width);
        return MAX_W'(1) << (width - 1);
    endfunction

    function automatic logic [MAX_W-1:0] saturate(input logic ovf,
                                                  input logic [MAX_W-1:0] val,
                                                  input int unsigned width);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << width) - MAX_W'(1);
        return ovf ? mask : (val & mask);
    endfunction

endpackage

// File: rtl/pwls_noise_shaper.sv
// First-order error-feedback requantizer from BITS down to PWM_BITS.
module pwls_noise_shaper
    import pwls_output_pkg::*;
#(
    parameter int unsigned BITS     = 12,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_load,
    input  logic [BITS-1:0]            i_pending,
    input  logic                       i_mute,
    input  logic [BITS-PWM_BITS-1:0]   i_dither,
    output logic [PWM_BITS-1:0]        o_quant
);

    localparam int unsigned FRAC_BITS = BITS - PWM_BITS;

    logic [FRAC_BITS-1:0] r_err;
    logic [PWM_BITS-1:0]  r_quant;
    logic [BITS:0]        w_sum;
    logic                 w_sat;
    logic [PWM_BITS-1:0]  w_quant;
    logic [FRAC_BITS-1:0] w_err;

    assign w_sum   = {1'b0, i_pending} + (BITS+1)'(r_err) + (BITS+1)'(i_dither);
    assign w_sat   = w_sum[BITS];
    assign w_quant = PWM_BITS'(saturate(w_sat, MAX_W'(w_sum[BITS:FRAC_BITS]), PWM_BITS));
    assign w_err   = w_sat ? '1 : w_sum[FRAC_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_quant <= PWM_BITS'(midscale(PWM_BITS));
            r_err   <= '0;
        end else if (i_load) begin
            if (i_mute) begin
                r_quant <= PWM_BITS'(midscale(PWM_BITS));
                r_err   <= '0;
            end else begin
                r_quant <= w_quant;
                r_err   <= w_err;
            end
        end
    end

    assign o_quant = r_quant;

endmodule

// File: rtl/pwls_pwm_output.sv
// PWM output stage: sample capture, period counter and pin driver.
// Optional LFSR dither on the requantizer is enabled by PWLS_PWM_DITHER_EN.
module pwls_pwm_output
    import pwls_output_pkg::*;
#(
    parameter int unsigned BITS     = 12,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [BITS-1:0]     sample_in,
    input  logic                mute,
    input  logic                overrun_clr,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] active_sample,
    output logic                period_strobe,
    output logic                overrun
);

    localparam int unsigned FRAC_BITS = BITS - PWM_BITS;

    logic [PWM_BITS-1:0]  r_counter;
    logic [BITS-1:0]      r_pending;
    logic                 r_fresh;
    logic                 r_overrun;
    logic                 r_pwm;
    logic                 r_strobe;
    logic                 w_boundary;
    logic [FRAC_BITS-1:0] w_dither;
    logic [PWM_BITS-1:0]  w_active;

    assign w_boundary = (r_counter == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter <= '0;
            r_pwm     <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_counter <= r_counter + PWM_BITS'(1);
            r_pwm     <= (r_counter < w_active);
            r_strobe  <= w_boundary;
        end
    end

    // Newer sample always wins; a second arrival before the boundary is an overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= BITS'(midscale(BITS));
            r_fresh   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (sample_valid) begin
                r_pending <= {~sample_in[BITS-1], sample_in[BITS-2:0]};
                r_fresh   <= 1'b1;
            end else if (w_boundary) begin
                r_fresh   <= 1'b0;
            end
            if (overrun_clr) begin
                r_overrun <= 1'b0;
            end else if (sample_valid && r_fresh && !w_boundary) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef PWLS_PWM_DITHER_EN
    logic [LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_boundary) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_dither = mute ? '0 : FRAC_BITS'(r_lfsr[FRAC_BITS-2:0]);
`else
    assign w_dither = '0;
`endif

    pwls_noise_shaper #(
        .BITS     (BITS),
        .PWM_BITS (PWM_BITS)
    ) u_shaper (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_boundary),
        .i_pending (r_pending),
        .i_mute    (mute),
        .i_dither  (w_dither),
        .o_quant   (w_active)
    );

    assign pwm_out       = r_pwm;
    assign active_sample = w_active;
    assign period_strobe = r_strobe;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_pwls_pwm_output.sv
// Directed scoreboard bench for pwls_pwm_output (BITS=12, PWM_BITS=8).
module tb_pwls_pwm_output;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample_in;
    logic        mute;
    logic        overrun_clr;
    logic        pwm_out;
    logic [7:0]  active_sample;
    logic        period_strobe;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [11:0] m_pend;
    logic [3:0]  m_err;
    logic [7:0]  m_act;
    logic [15:0] m_lfsr;
    logic        m_ovr;

    always #5 clk = ~clk;

    pwls_pwm_output #(.BITS(12), .PWM_BITS(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .mute          (mute),
        .overrun_clr   (overrun_clr),
        .pwm_out       (pwm_out),
        .active_sample (active_sample),
        .period_strobe (period_strobe),
        .overrun       (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_offset(input logic [11:0] s);
        return {~s[11], s[10:0]};
    endfunction

    task automatic model_reset();
        m_pend = 12'h800;
        m_err  = 4'h0;
        m_act  = 8'h80;
        m_lfsr = 16'hACE1;
        m_ovr  = 1'b0;
        exp_q.delete();
    endtask

    // Reference boundary update; pushes the expected next active_sample
    task automatic model_boundary(input logic m);
        logic [12:0] sum;
        logic [3:0]  d;
        d = 4'h0;
`ifdef PWLS_PWM_DITHER_EN
        if (!m) d = {1'b0, m_lfsr[2:0]};
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        sum = {1'b0, m_pend} + 13'(m_err) + 13'(d);
        if (m) begin
            m_act = 8'h80;
            m_err = 4'h0;
        end else if (sum[12]) begin
            m_act = 8'hFF;
            m_err = 4'hF;
        end else begin
            m_act = sum[11:4];
            m_err = sum[3:0];
        end
        exp_q.push_back(m_act);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(active_sample), 32'(e));
        end
    endtask

    task automatic wait_strobe(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (period_strobe === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_strobe_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic sync_period(input string tag);
        wait_strobe(tag);
        model_boundary(mute);
        pop_check({tag, "_active"});
    endtask

    // One full PWM period starting at the counter==0 cycle.
    // mode 0: no strobe, 1: one strobe, 2: two strobes, 3: strobe on the boundary cycle
    task automatic play_period(input string tag, input logic [11:0] s1, input logic [11:0] s2,
                               input int mode, input logic m);
        int         hi;
        logic [7:0] prev_act;
        hi       = 0;
        prev_act = m_act;
        mute     = m;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi += int'(pwm_out);
            sample_valid = 1'b0;
            if ((mode == 1 || mode == 2) && i == 10) begin
                sample_valid = 1'b1;
                sample_in    = s1;
                m_pend       = to_offset(s1);
            end
            if (mode == 2 && i == 20) begin
                sample_valid = 1'b1;
                sample_in    = s2;
                m_pend       = to_offset(s2);
                m_ovr        = 1'b1;
            end
            if (i == 254) begin
                model_boundary(m);
                if (mode == 3) begin
                    sample_valid = 1'b1;
                    sample_in    = s1;
                    m_pend       = to_offset(s1);
                end
            end
        end
        check({tag, "_strobe"},  32'(period_strobe), 32'd1);
        check({tag, "_hi"},      32'(hi), 32'(prev_act));
        pop_check({tag, "_active"});
        check({tag, "_err"},     32'(dut.u_shaper.r_err), 32'(m_err));
        check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 12'h000;
        mute         = 1'b0;
        overrun_clr  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_counter", 32'(dut.r_counter), 32'h0);
        check("rst_active",  32'(active_sample), 32'h80);
        check("rst_pwm",     32'(pwm_out), 32'h0);
        check("rst_strobe",  32'(period_strobe), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_err",     32'(dut.u_shaper.r_err), 32'h0);
        reset = 1'b0;

        sync_period("sync0");

        // midscale
        play_period("mid0", 12'h000, 12'h000, 1, 1'b0);
        play_period("mid1", 12'h000, 12'h000, 1, 1'b0);

        // positive and negative saturation
        play_period("satp0", 12'h7FF, 12'h000, 1, 1'b0);
        play_period("satp1", 12'h7FF, 12'h000, 1, 1'b0);
        play_period("satp2", 12'h7FF, 12'h000, 1, 1'b0);
        play_period("satn0", 12'h800, 12'h000, 1, 1'b0);
        play_period("satn1", 12'h800, 12'h000, 1, 1'b0);
        play_period("satn2", 12'h800, 12'h000, 1, 1'b0);

        // noise shaping
        for (int k = 0; k < 4; k++) play_period("shape", 12'h008, 12'h000, 1, 1'b0);

        // overrun then clear
        play_period("ovr", 12'h100, 12'h200, 2, 1'b0);
        play_period("ovr_play", 12'h000, 12'h000, 0, 1'b0);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        m_ovr       = 1'b0;
        check("ovr_clr", 32'(overrun), 32'h0);
        sync_period("sync1");

        // strobe coincident with the boundary
        play_period("coin", 12'h300, 12'h000, 3, 1'b0);
        play_period("coin_play", 12'h000, 12'h000, 0, 1'b0);
        play_period("coin_after", 12'h000, 12'h000, 1, 1'b0);

        // mute with full-scale input
        play_period("mute", 12'h7FF, 12'h000, 1, 1'b1);
        play_period("unmute", 12'h000, 12'h000, 1, 1'b0);

        // reset mid-period with overrun set
        play_period("ovr2", 12'h100, 12'h200, 2, 1'b0);
        repeat (8'h40) @(negedge clk);
        check("pre_rst_counter", 32'(dut.r_counter), 32'h40);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("mid_rst_counter", 32'(dut.r_counter), 32'h0);
        check("mid_rst_pwm",     32'(pwm_out), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        check("mid_rst_active",  32'(active_sample), 32'h80);
        sync_period("sync2");
        for (int k = 0; k < 3; k++) play_period("post_rst", 12'h000, 12'h000, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwls_pwm_output.md
Name: pwls_pwm_output

Overview:
- Downstream output stage for the PWL synth channel/ALU path.
- Captures the finished signed sample presented on the accumulator output once per sample period.
- Applies first-order error-feedback noise shaping from BITS down to PWM_BITS.
- Drives a single-bit PWM pin for an external RC filter; also exposes the active quantized sample for test/debug.

Parameters:
- BITS, 12: width of incoming signed sample (matches channel acc_out width).
- PWM_BITS, 8: PWM resolution; period = 2^PWM_BITS clk cycles; must be < BITS.
- FRAC_BITS, BITS-PWM_BITS: derived, not overridable; bits carried in the error register.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- sample_valid  input  1  one-cycle strobe: sample_in holds a completed sample (driven from the ALU next_sample timing).
- sample_in  input  BITS  signed two's-complement sample.
- mute  input  1  force midscale output.
- overrun_clr  input  1  clears the overrun flag.
- pwm_out  output  1  registered PWM output.
- active_sample  output  PWM_BITS  duty value currently being played (offset binary).
- period_strobe  output  1  high for one cycle on the cycle after each PWM period boundary.
- overrun  output  1  sticky: more than one sample arrived within one PWM period.

Behaviour:
- Reset values:
  - counter 0.
  - pending = 2^(BITS-1), i.e. midscale offset binary.
  - active_sample = 2^(PWM_BITS-1).
  - err 0; pwm_out 0; period_strobe 0; overrun 0.
  - fresh flag 0.
- Sample capture:
  - On sample_valid, pending <= sample_in with MSB inverted (signed to offset binary).
  - fresh <= 1.
  - If fresh is already 1 and no boundary occurs this cycle, overrun <= 1. The newer sample replaces the older one.
- Counter:
  - PWM_BITS-bit free-running up-counter.
  - Boundary = cycle where counter == 2^PWM_BITS-1; counter wraps to 0 on that edge.
- At the boundary edge:
  - sum = {1'b0,pending} + err (BITS+1 bits).
  - active_sample <= sum[BITS:FRAC_BITS], saturated to 2^PWM_BITS-1 if sum[BITS] is set.
  - err <= sum[FRAC_BITS-1:0], or all ones when saturated.
  - fresh <= 0.
- Boundary and sample_valid in the same cycle:
  - The boundary uses the old pending value.
  - The new sample lands in pending with fresh <= 1.
  - No overrun is flagged.
- Mute is sampled at the boundary:
  - If mute is 1, active_sample <= 2^(PWM_BITS-1) and err <= 0.
  - pending is still updated as usual.
- pwm_out <= (counter < active_sample), evaluated on current register values.
  - Gives exactly active_sample high cycles per period.
  - Delayed one cycle relative to the counter.
  - active_sample = 0 gives a constant low output; maximum duty is (2^PWM_BITS-1)/2^PWM_BITS.
- Latency: a sample accepted before a boundary first affects pwm_out on the cycle after that boundary.
- period_strobe <= boundary, so it is high in the cycle where counter == 0.
- overrun_clr has priority over setting overrun in the same cycle.
- Reset mid-period:
  - All state returns to reset values next cycle.
  - The period restarts at counter 0; no partial pulse is required.

Optional Feature:
- Macro PWLS_PWM_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR is added: taps 16,14,13,11; seed 16'hACE1 on reset; steps once per boundary.
  - The boundary sum adds dither = lfsr[FRAC_BITS-2:0], zero-extended.
  - Mute also zeroes the dither contribution.
- Not defined:
  - No LFSR flops exist; dither = 0.
  - Behaviour is bit-exact with the description above.

Decomposition:
- Package pwls_output_pkg holds:
  - Midscale constants.
  - The LFSR seed and tap mask.
  - The saturate helper function.
- One sub-module, pwls_noise_shaper, contains:
  - The sum, saturation and err register.
  - Inputs: load strobe, pending, mute, dither.
  - Output: quantized value.
- The top level contains the counter, capture/fresh/overrun logic and pwm_out.

Test Plan (BITS=12, PWM_BITS=8, macro off unless stated):
- Midscale: sample_in=0x000 strobed each period -> active_sample=0x80; pwm_out high 128 of every 256 cycles.
- Saturation: sample_in=0x7FF -> active_sample=0xFF; err stays 0xF; pwm_out low exactly 1 cycle per period. sample_in=0x800 -> active_sample=0x00; pwm_out constantly low.
- Noise shaping: sample_in=0x008 (offset 0x808) -> active_sample alternates 0x80,0x81 over consecutive periods; mean duty 128.5.
- Overrun and simultaneous events:
  - Two strobes (0x100, then 0x200) within one period -> overrun=1; next active_sample=0xA0.
  - A strobe coinciding with the boundary -> no overrun; the old value is played.
  - overrun_clr -> overrun=0.
- Mute and reset:
  - mute=1 with sample_in=0x7FF -> active_sample=0x80, err=0.
  - Reset asserted at counter=0x40 -> counter=0, pwm_out=0, overrun=0 next cycle.
- Dither build (PWLS_PWM_DITHER_EN): constant sample_in=0x000 -> active_sample ∈ {0x80,0x81}; the sequence matches a reference LFSR model seeded 0xACE1.
